dfx_recv_fifo: RTL and testbench

Parametrised synchronous receive FIFO for DFX data in the router write arbiter, one instance per lane. Buffers incoming flits from the lane receiver until the write arbiter grants them, with configurable width and depth, standard or first-word-fall-through read mode, almost-full back-pressure and sticky overflow/underflow error flags. Simultaneous push and pop are fully defined at every occupancy, including full and empty.

---
 rtl/dfx_recv_fifo_pkg.sv | 18 +
 rtl/dfx_recv_fifo_if.sv | 36 +++
 rtl/dfx_recv_fifo_mem.sv | 31 +++
 rtl/dfx_recv_fifo.sv | 106 ++++++++++
 tb/tb_dfx_recv_fifo.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/dfx_recv_fifo_pkg.sv
// dfx_recv_fifo_pkg
// Shared constants and types for the per-lane DFX receive FIFO.
//   DFX_FLIT_W     : width of one DFX flit in bits
//   dfx_flit_t     : one flit
//   DFX_FIFO_DEPTH : default FIFO depth in entries
//   is_pow2()      : true for powers of two that are at least 2
package dfx_recv_fifo_pkg;

  localparam int DFX_FLIT_W     = 1034;
  localparam int DFX_FIFO_DEPTH = 4;

  typedef logic [DFX_FLIT_W-1:0] dfx_flit_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/dfx_recv_fifo_if.sv
// dfx_recv_fifo_if
// Push/pop handshake, status and error bundle of one receive FIFO lane.
//   master : lane receiver / write arbiter side (drives wr_*, rd_en, clr_err)
//   slave  : the FIFO itself
interface dfx_recv_fifo_if #(
  parameter int WIDTH = 1034,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, empty, full, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, empty, full, almost_full, count,
           overflow, underflow
  );

endinterface

// File: rtl/dfx_recv_fifo_mem.sv
// dfx_recv_fifo_mem
// DEPTH x WIDTH storage, one synchronous write port, one asynchronous read
// port, no reset (maps to distributed RAM or plain flops).
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module dfx_recv_fifo_mem #(
  parameter int WIDTH = 1034,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dfx_recv_fifo.sv
// dfx_recv_fifo
// Synchronous receive FIFO for one DFX lane of the router write arbiter.
// Standard (registered) or first-word-fall-through read, almost-full
// back-pressure, sticky overflow/underflow flags.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : dfx_recv_fifo_if.slave (push/pop handshake, status, error flags)
module dfx_recv_fifo
  import dfx_recv_fifo_pkg::*;
#(
  parameter int WIDTH     = DFX_FLIT_W,
  parameter int DEPTH     = DFX_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter bit FWFT      = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  dfx_recv_fifo_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("dfx_recv_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("dfx_recv_fifo: AF_THRESH must be within 1..DEPTH");
    end
  endgenerate

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             overflow_r;
  logic             underflow_r;
  logic [WIDTH-1:0] head;

  logic empty_s;
  logic full_s;
  logic push_ok;
  logic pop_ok;

  // Flags come only from registered occupancy, never from wr_en/rd_en.
  assign empty_s = (count_r == '0);
  assign full_s  = (count_r == CW'(DEPTH));

  // Acceptance is judged on the pre-edge state, so a pop on an empty FIFO
  // never sees a same-cycle push, and a push on a full FIFO is dropped even
  // if a pop frees a slot in that cycle.
  assign push_ok = bus.wr_en && !full_s;
  assign pop_ok  = bus.rd_en && !empty_s;

  dfx_recv_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !rst),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      rd_data_r   <= '0;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);

      if (push_ok && !pop_ok)      count_r <= count_r + CW'(1);
      else if (pop_ok && !push_ok) count_r <= count_r - CW'(1);

      rd_valid_r <= pop_ok;
      if (pop_ok) rd_data_r <= head;

      // A new error in the same cycle as clr_err keeps the flag set.
      if (bus.wr_en && full_s)       overflow_r  <= 1'b1;
      else if (bus.clr_err)          overflow_r  <= 1'b0;
      if (bus.rd_en && empty_s)      underflow_r <= 1'b1;
      else if (bus.clr_err)          underflow_r <= 1'b0;
    end
  end

  assign bus.rd_data     = FWFT ? head     : rd_data_r;
  assign bus.rd_valid    = FWFT ? !empty_s : rd_valid_r;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = (count_r >= CW'(AF_THRESH));
  assign bus.count       = count_r;
  assign bus.overflow    = overflow_r;
  assign bus.underflow   = underflow_r;

endmodule

// File: tb/tb_dfx_recv_fifo.sv
// tb_dfx_recv_fifo
// Drives one standard-mode and one FWFT instance (DEPTH=4, WIDTH=16) with
// identical stimulus and compares both against a queue-based reference.
module tb_dfx_recv_fifo;

  localparam int W = 16;
  localparam int D = 4;
  localparam int AF = D - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dfx_recv_fifo_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  dfx_recv_fifo_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  dfx_recv_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .FWFT(1'b0)) u_std (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  dfx_recv_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .FWFT(1'b1)) u_fwft (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference state
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_rdv;
  logic [W-1:0] m_rdd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit w, input logic [W-1:0] d, input bit r,
                       input bit c, input bit rs);
    bit was_full, was_empty;
    if (rs) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      m_rdv = r && !was_empty;
      if (m_rdv) m_rdd = q.pop_front();
      if (w && !was_full) q.push_back(d);
      m_ovf = (w && was_full)  || (m_ovf && !c);
      m_unf = (r && was_empty) || (m_unf && !c);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_std",  32'(bus0.count), 32'(n));
    chk("count_fwft", 32'(bus1.count), 32'(n));
    chk("empty",      32'(bus0.empty), 32'(n == 0));
    chk("full",       32'(bus0.full),  32'(n == D));
    chk("almost_full",32'(bus0.almost_full), 32'(n >= AF));
    chk("overflow",   32'(bus0.overflow),  32'(m_ovf));
    chk("underflow",  32'(bus0.underflow), 32'(m_unf));
    chk("ovf_fwft",   32'(bus1.overflow),  32'(m_ovf));
    chk("unf_fwft",   32'(bus1.underflow), 32'(m_unf));
    chk("rd_valid_std",  32'(bus0.rd_valid), 32'(m_rdv));
    chk("rd_data_std",   32'(bus0.rd_data),  32'(m_rdd));
    chk("rd_valid_fwft", 32'(bus1.rd_valid), 32'(n != 0));
    if (n != 0) chk("rd_data_fwft", 32'(bus1.rd_data), 32'(q[0]));
  endtask

  task automatic step(input bit w, input logic [W-1:0] d, input bit r,
                      input bit c, input bit rs);
    rst = rs;
    bus0.wr_en = w; bus0.wr_data = d; bus0.rd_en = r; bus0.clr_err = c;
    bus1.wr_en = w; bus1.wr_data = d; bus1.rd_en = r; bus1.clr_err = c;
    @(posedge clk);
    #1;
    model(w, d, r, c, rs);
    check_all();
  endtask

  initial begin
    logic [W-1:0] got[$];
    rst = 1'b1;
    bus0.wr_en = 0; bus0.wr_data = '0; bus0.rd_en = 0; bus0.clr_err = 0;
    bus1.wr_en = 0; bus1.wr_data = '0; bus1.rd_en = 0; bus1.clr_err = 0;

    // reset, with push/pop requests that must be ignored
    step(1, 16'h1234, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // fill / drain
    step(1, 16'hA, 0, 0, 0);
    step(1, 16'hB, 0, 0, 0);
    step(1, 16'hC, 0, 0, 0);
    step(1, 16'hD, 0, 0, 0);
    chk("fill_full", 32'(bus0.full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("drain_data", 32'(bus0.rd_data), 32'(16'hA + i));
    end
    step(0, 0, 0, 0, 0);

    // simultaneous push/pop at count=2, then at full
    step(1, 16'h1, 0, 0, 0);
    step(1, 16'h2, 0, 0, 0);
    step(1, 16'h5, 1, 0, 0);
    step(1, 16'h6, 0, 0, 0);
    step(1, 16'h7, 0, 0, 0);
    step(1, 16'h8, 1, 0, 0);
    chk("full_pushpop_count", 32'(bus0.count), 32'd3);
    chk("full_pushpop_ovf",   32'(bus0.overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // underflow and clearing
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("unf_set_wins", 32'(bus0.underflow), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("unf_cleared", 32'(bus0.underflow), 32'd0);

    // wrap-around: push 1, then push k while popping, then final pop
    step(1, 16'd1, 0, 0, 0);
    for (int k = 2; k <= 10; k++) begin
      step(1, W'(k), 1, 0, 0);
      if (bus0.rd_valid) got.push_back(bus0.rd_data);
    end
    step(0, 0, 1, 0, 0);
    if (bus0.rd_valid) got.push_back(bus0.rd_data);
    chk("wrap_len", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++) chk("wrap_seq", 32'(got[i]), 32'(i + 1));

    // FWFT head visibility and acknowledge
    step(1, 16'h77, 0, 0, 0);
    chk("fwft_head", 32'(bus1.rd_data), 32'h77);
    step(0, 0, 1, 0, 0);

    // reset mid-operation
    step(1, 16'h3, 0, 0, 0);
    step(1, 16'h4, 0, 0, 0);
    step(1, 16'h5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0); // underflow
    step(1, 16'h9, 0, 0, 0);
    step(1, 16'hA, 0, 0, 0);
    step(1, 16'hB, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_count", 32'(bus0.count), 32'd0);
    step(1, 16'h1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("post_rst_data", 32'(bus0.rd_data), 32'h1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
